// File: rtl/bus_rr_arbiter_pkg.sv
// rtl/bus_rr_arbiter_pkg.sv - shared types and defaults for the round-robin bus arbiter
package bus_rr_arbiter_pkg;

  localparam int N_REQ_DEF = 13;
  localparam int SEL_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// rtl/bus_rr_arbiter_rr_pick.sv - combinational rotate/priority-encode of the request vector
module rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_last_grant,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any_valid
);

  logic [N_REQ-1:0] w_upper_mask;
  logic [N_REQ-1:0] w_upper_req;
  logic [N_REQ-1:0] w_pool;

  always_comb begin
    w_upper_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_upper_mask[i] = (SEL_W'(i) > i_last_grant);
    end
  end

  // Requests above last_grant win first; otherwise wrap around to index 0.
  assign w_upper_req = i_req & w_upper_mask;
  assign w_pool      = (|w_upper_req) ? w_upper_req : i_req;

  always_comb begin
    o_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_pool[i]) begin
        o_winner = SEL_W'(i);
      end
    end
  end

  assign o_any_valid = |i_req;

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter driving the shared 32-bit source mux select
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_e           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;

  state_e           w_state_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] w_last_nxt;
  logic [N_REQ-1:0] w_done;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic [N_REQ-1:0] w_winner_oh;
  logic             w_owner_req;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_winner     (w_winner),
    .o_any_valid  (w_any)
  );

  assign w_winner_oh = N_REQ'(1) << w_winner;
  assign w_owner_req = |(req & r_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= SEL_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // last_grant already equals the current owner, so a completion search
  // starts just past it and only falls back to the owner when nobody else asks.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_done      = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = w_winner_oh;
          w_sel_nxt   = w_winner;
          w_last_nxt  = w_winner;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      BUSY: begin
        if (out_ready) begin
          w_done = r_gnt;
          if (w_any) begin
            w_gnt_nxt  = w_winner_oh;
            w_sel_nxt  = w_winner;
            w_last_nxt = w_winner;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign done      = w_done;
  assign out_valid = (r_state == BUSY);
  assign busy      = (r_state == BUSY);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - scoreboard bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

  typedef struct packed {
    logic        v;
    logic [3:0]  sel;
    logic [12:0] gnt;
    logic [12:0] done;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [12:0] req;
  logic [12:0] gnt;
  logic [12:0] done;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  logic rand_phase;
  int   starve[13];
  logic prev_valid;
  logic prev_cmpl;
  logic [3:0]  prev_sel;
  logic [12:0] prev_gnt;

  bus_rr_arbiter #(
    .N_REQ (13),
    .SEL_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic step(input logic [12:0] r, input logic rdy, input logic ev,
                      input logic [3:0] es, input logic [12:0] eg, input logic [12:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    e.v    = ev;
    e.sel  = es;
    e.gnt  = eg;
    e.done = ed;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    a = {out_valid, sel, gnt, done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e || busy !== e.v) begin
        n_errors++;
        $display("FAIL sb_cycle: got v=%0b busy=%0b sel=%0d gnt=0x%0h done=0x%0h expected v=%0b sel=%0d gnt=0x%0h done=0x%0h",
                 out_valid, busy, sel, gnt, done, e.v, e.sel, e.gnt, e.done);
      end
    end else if (!rand_phase) begin
      n_checks++;
      if (out_valid !== 1'b0 || gnt !== 13'h0 || done !== 13'h0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got v=%0b gnt=0x%0h done=0x%0h expected idle", out_valid, gnt, done);
      end
    end
    if (rand_phase) begin
      n_checks++;
      if (!$onehot0(gnt)) begin
        n_errors++;
        $display("FAIL rnd_onehot: got gnt=0x%0h expected one-hot or zero", gnt);
      end
      n_checks++;
      if (sel > 4'd12) begin
        n_errors++;
        $display("FAIL rnd_sel_range: got sel=%0d expected <13", sel);
      end
      n_checks++;
      if (gnt !== (out_valid ? (13'd1 << sel) : 13'd0) || busy !== out_valid) begin
        n_errors++;
        $display("FAIL rnd_gnt_sel: got gnt=0x%0h sel=%0d v=%0b busy=%0b expected gnt matching sel", gnt, sel, out_valid, busy);
      end
      n_checks++;
      if (done !== ((out_valid && out_ready) ? gnt : 13'd0)) begin
        n_errors++;
        $display("FAIL rnd_done: got done=0x%0h expected 0x%0h", done, (out_valid && out_ready) ? gnt : 13'd0);
      end
      if (prev_valid && !prev_cmpl && out_valid) begin
        n_checks++;
        if (sel !== prev_sel || gnt !== prev_gnt) begin
          n_errors++;
          $display("FAIL rnd_stable: got sel=%0d gnt=0x%0h expected sel=%0d gnt=0x%0h", sel, gnt, prev_sel, prev_gnt);
        end
      end
      for (int i = 0; i < 13; i++) begin
        if (!req[i] || gnt[i]) begin
          starve[i] = 0;
        end else if (done != 13'd0) begin
          starve[i] = starve[i] + 1;
          n_checks++;
          if (starve[i] > 13) begin
            n_errors++;
            $display("FAIL rnd_starve: requester %0d waited %0d completions expected <=13", i, starve[i]);
          end
        end
      end
    end
    prev_valid = out_valid;
    prev_cmpl  = out_valid && out_ready;
    prev_sel   = sel;
    prev_gnt   = gnt;
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rand_phase = 1'b0;
    prev_valid = 1'b0;
    prev_cmpl  = 1'b0;
    prev_sel   = '0;
    prev_gnt   = '0;
    for (int i = 0; i < 13; i++) starve[i] = 0;
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #1;
    check("reset_gnt",   32'(gnt), 32'h0);
    check("reset_sel",   32'(sel), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_busy",  32'(busy), 32'h0);
    check("reset_done",  32'(done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single requester: grant, complete, re-grant, abort
    step(13'h0001, 1'b0, 1'b0, 4'd0, 13'h0000, 13'h0000);
    step(13'h0001, 1'b1, 1'b1, 4'd0, 13'h0001, 13'h0001);
    step(13'h0000, 1'b0, 1'b1, 4'd0, 13'h0001, 13'h0000);
    step(13'h0000, 1'b0, 1'b0, 4'd0, 13'h0000, 13'h0000);

    // all requesting, always ready: 0..12 then wrap to 0
    do_reset();
    step(13'h1FFF, 1'b1, 1'b0, 4'd0, 13'h0000, 13'h0000);
    for (int k = 0; k < 13; k++) begin
      step(13'h1FFF, 1'b1, 1'b1, 4'(k), 13'(1 << k), 13'(1 << k));
    end
    step(13'h1FFF, 1'b1, 1'b1, 4'd0, 13'h0001, 13'h0001);
    step(13'h0000, 1'b0, 1'b1, 4'd1, 13'h0002, 13'h0000);
    step(13'h0000, 1'b0, 1'b0, 4'd1, 13'h0000, 13'h0000);

    // grant 5 stalled while 7 arrives
    do_reset();
    step(13'h0020, 1'b0, 1'b0, 4'd0, 13'h0000, 13'h0000);
    for (int k = 0; k < 4; k++) begin
      step(13'h00A0, 1'b0, 1'b1, 4'd5, 13'h0020, 13'h0000);
    end
    step(13'h00A0, 1'b1, 1'b1, 4'd5, 13'h0020, 13'h0020);
    step(13'h0000, 1'b0, 1'b1, 4'd7, 13'h0080, 13'h0000);
    step(13'h0000, 1'b0, 1'b0, 4'd7, 13'h0000, 13'h0000);

    // abort of 3, next search starts at 4
    do_reset();
    step(13'h0008, 1'b0, 1'b0, 4'd0, 13'h0000, 13'h0000);
    step(13'h0000, 1'b0, 1'b1, 4'd3, 13'h0008, 13'h0000);
    step(13'h0014, 1'b0, 1'b0, 4'd3, 13'h0000, 13'h0000);
    step(13'h0000, 1'b0, 1'b1, 4'd4, 13'h0010, 13'h0000);
    step(13'h0000, 1'b0, 1'b0, 4'd4, 13'h0000, 13'h0000);

    // reset in the middle of a transaction to 9
    do_reset();
    step(13'h0200, 1'b0, 1'b0, 4'd0, 13'h0000, 13'h0000);
    step(13'h0200, 1'b0, 1'b1, 4'd9, 13'h0200, 13'h0000);
    @(negedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("pre_reset_done", 32'(done), 32'h200);
    rst_n = 1'b0;
    #1;
    check("midrst_gnt",   32'(gnt), 32'h0);
    check("midrst_sel",   32'(sel), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_busy",  32'(busy), 32'h0);
    check("midrst_done",  32'(done), 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    step(13'h0201, 1'b0, 1'b0, 4'd0, 13'h0000, 13'h0000);
    step(13'h0201, 1'b1, 1'b1, 4'd0, 13'h0001, 13'h0001);
    step(13'h0000, 1'b0, 1'b1, 4'd9, 13'h0200, 13'h0000);
    step(13'h0000, 1'b0, 1'b0, 4'd9, 13'h0000, 13'h0000);
    @(negedge clk);
    #1;

    rand_phase = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      end
      out_ready = ($urandom_range(1) == 1);
    end
    @(negedge clk);
    #1;
    rand_phase = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
